led_blink_scheduler: RTL and testbench

Shares one status LED among NUM_REQ requesters. Each requester asks for a blink code, which is a number of blinks. A round-robin arbiter picks one requester, and an FSM plays its blinks at a fixed half-period, holds an inter-code gap, then acks. This gives multi-source status signalling on a board with a single LED.

---
 rtl/led_sched_pkg.sv | 25 ++
 rtl/led_rr_arbiter.sv | 52 +++++
 rtl/led_blink_scheduler.sv | 120 ++++++++++++
 tb/tb_led_blink_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_sched_pkg                                                         |
// | Shared state encoding and sizing helper for the LED blink scheduler.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package led_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_rr_arbiter                                                        |
// | Round-robin pick of the first request at or after the pointer.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module led_rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  input  logic [ID_W-1:0]    i_upd_id,
  output logic               o_found,
  output logic [ID_W-1:0]    o_pick
);

  localparam logic [ID_W:0]   c_num  = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_sum;

  always_comb begin
    o_found = 1'b0;
    o_pick  = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_sum >= c_num) w_sum = w_sum - c_num;
      if (!o_found && i_req[w_sum[ID_W-1:0]]) begin
        o_found = 1'b1;
        o_pick  = w_sum[ID_W-1:0];
      end
    end
  end

  // The served index drops to lowest priority once its turn ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (i_upd_id == c_last) ? '0 : i_upd_id + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_blink_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_blink_scheduler                                                   |
// | Shares one LED among requesters, playing each blink code in turn.     |
// | Optional: LED_SCHED_ABORT_EN cancels a code when its req drops.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 4,
  parameter int HALF_PERIOD = 10,
  parameter int GAP         = 30,
  parameter int TIMER_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*CNT_W-1:0]      req_blinks,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [clog2_min1(NUM_REQ)-1:0] grant_id,
  output logic                          led
);

  localparam int ID_W = clog2_min1(NUM_REQ);
  localparam logic [TIMER_W-1:0] c_half_last = TIMER_W'(HALF_PERIOD - 1);
  localparam logic [TIMER_W-1:0] c_gap_last  = TIMER_W'(GAP - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_remaining;
  logic               w_found;
  logic [ID_W-1:0]    w_pick;
  logic [ID_W-1:0]    w_sel_id;
  logic               w_upd;
  logic [CNT_W-1:0]   w_blinks [NUM_REQ];
  logic [CNT_W-1:0]   w_pick_blinks;
  logic [NUM_REQ-1:0] w_ack_nxt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_field
    assign w_blinks[gi] = req_blinks[gi*CNT_W +: CNT_W];
  end

  assign w_pick_blinks = w_blinks[w_pick];

  led_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_upd    (w_upd),
    .i_upd_id (grant_id),
    .o_found  (w_found),
    .o_pick   (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_sel_id    = grant_id;
    w_ack_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        w_sel_id = w_pick;
        if (w_found) w_state_nxt = (w_pick_blinks != '0) ? ST_ON : ST_DONE;
      end
      ST_ON:   if (r_timer == c_half_last) w_state_nxt = ST_OFF;
      ST_OFF: begin
        // Looks at the count before its decrement on leaving OFF.
        if (r_timer == c_half_last)
          w_state_nxt = (r_remaining > CNT_W'(1)) ? ST_ON : ST_GAP;
      end
      ST_GAP:  if (r_timer == c_gap_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_upd       = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
`ifdef LED_SCHED_ABORT_EN
    if ((r_state == ST_ON || r_state == ST_OFF) && !req[grant_id]) begin
      w_state_nxt = ST_IDLE;
      w_upd       = 1'b1;
    end
`endif
    if (w_state_nxt == ST_DONE) w_ack_nxt[w_sel_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      grant_id    <= '0;
      led         <= 1'b0;
      ack         <= '0;
      busy        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || r_state == ST_IDLE) r_timer <= '0;
      else                                               r_timer <= r_timer + 1'b1;
      if (r_state == ST_IDLE && w_found) begin
        grant_id    <= w_pick;
        r_remaining <= w_pick_blinks;
      end else if (r_state == ST_OFF && w_state_nxt != ST_OFF) begin
        r_remaining <= r_remaining - 1'b1;
      end
      led  <= (w_state_nxt == ST_ON);
      busy <= (w_state_nxt != ST_IDLE);
      ack  <= w_ack_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_led_blink_scheduler                                                |
// | Scoreboard bench: predicted grants/traces vs. observed LED sequences. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_led_blink_scheduler;

  localparam int NR = 4;
  localparam int CW = 4;
  localparam int HP = 2;
  localparam int GP = 3;
  localparam int TW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*CW-1:0] req_blinks = '0;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [1:0]       grant_id;
  logic             led;

  always #5 clk = ~clk;

  led_blink_scheduler #(
    .NUM_REQ     (NR),
    .CNT_W       (CW),
    .HALF_PERIOD (HP),
    .GAP         (GP),
    .TIMER_W     (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_blinks (req_blinks),
    .ack        (ack),
    .busy       (busy),
    .grant_id   (grant_id),
    .led        (led)
  );

  typedef struct {
    int id;
    int blinks;
    int abort_k;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   idle_err = 0;
  int   quota[NR];
  int   bl_seq[NR][4];
  int   issue_idx[NR];
  int   reissue[NR];
  bit   pend[NR];
  int   model_ptr = 0;
  int   next_abort_k = -1;
  bit   in_txn = 1'b0;

  task automatic check(input string name, input bit ok, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // A code of n blinks: HP cycles on, HP off, n times, then GP low, then the ack cycle.
  function automatic bit exp_led(input int n, input int k);
    return (k < 2*n*HP) && (((k / HP) % 2) == 0);
  endfunction

  function automatic int done_k(input int n);
    return (n == 0) ? 0 : 2*n*HP + GP;
  endfunction

  // Monitor: one sample per cycle, shortly after the active edge.
  initial begin
    exp_t cur;
    int   k;
    int   mism;
    int   dk;
    bit   stray;
    k = 0; mism = 0; stray = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_txn = 1'b0;
        stray  = 1'b0;
        check("reset_state", led == 1'b0 && busy == 1'b0 && ack == '0 && grant_id == 2'd0,
              {led, busy, ack, grant_id}, 0);
      end else begin
        if (stray && !busy) stray = 1'b0;
        if (!in_txn && !stray && busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_txn", 1'b0, grant_id, -1);
            stray = 1'b1;
          end else begin
            cur    = exp_q.pop_front();
            k      = 0;
            mism   = 0;
            in_txn = 1'b1;
            check("grant_id", grant_id == cur.id[1:0], grant_id, cur.id);
          end
        end
        if (in_txn) begin
          dk = done_k(cur.blinks);
          if (cur.abort_k >= 0 && k == cur.abort_k + 1) begin
            check("abort_end", !busy && !led && ack == '0, {busy, led, ack}, 0);
            check("trace", mism == 0, mism, 0);
            in_txn = 1'b0;
          end else if (k <= dk) begin
            if (led != exp_led(cur.blinks, k)) mism++;
            if (!busy) mism++;
            if (k < dk && ack != '0) mism++;
            if (k == dk) check("ack", ack == NR'(1 << cur.id), ack, 1 << cur.id);
          end else begin
            check("busy_drop", !busy, busy, 0);
            check("trace", mism == 0, mism, 0);
            in_txn = 1'b0;
          end
          k++;
        end else if (!busy && !stray && (led || ack != '0)) begin
          idle_err++;
        end
      end
    end
  end

  // Requesters: drop on ack, optionally re-request one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          pend[i] = 1'b0;
          req_blinks[i*CW +: CW] = CW'(bl_seq[i][issue_idx[i]]);
          issue_idx[i]++;
          req[i] = 1'b1;
        end else if (ack[i] && req[i]) begin
          req[i] = 1'b0;
          if (reissue[i] > 0) begin
            reissue[i]--;
            pend[i] = 1'b1;
          end
        end
      end
    end
  end

  // Every requester with quota stays pending until served quota times,
  // so the service order is plain round-robin over the remaining quotas.
  task automatic start_batch();
    int q[NR];
    int kk[NR];
    int p;
    bit any;
    for (int i = 0; i < NR; i++) begin
      q[i]  = quota[i];
      kk[i] = 0;
    end
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      p   = 0;
      for (int s = 0; s < NR; s++) begin
        if (!any && q[(model_ptr + s) % NR] > 0) begin
          any = 1'b1;
          p   = (model_ptr + s) % NR;
        end
      end
      if (any) begin
        exp_q.push_back('{p, bl_seq[p][kk[p]], next_abort_k});
        kk[p]++;
        q[p]--;
        model_ptr = (p + 1) % NR;
      end
    end
    next_abort_k = -1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (quota[i] > 0) begin
        req_blinks[i*CW +: CW] = CW'(bl_seq[i][0]);
        issue_idx[i] = 1;
        reissue[i]   = quota[i] - 1;
        req[i]       = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit any_pend;
    n = 0;
    any_pend = 1'b1;
    while ((exp_q.size() != 0 || in_txn || busy || any_pend) && n < 2000) begin
      @(negedge clk);
      n++;
      any_pend = 1'b0;
      for (int i = 0; i < NR; i++) if (pend[i] || req[i]) any_pend = 1'b1;
    end
    check(name, n < 2000, n, 2000);
    if (n >= 2000) exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_led_edges(input string name, input int rises_req, input bit want_fall);
    int  rises;
    int  n;
    bit  prev;
    bit  done;
    rises = 0; n = 0; prev = 1'b0; done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (led && !prev) rises++;
      if (!want_fall && rises == rises_req) done = 1'b1;
      if (want_fall && rises == rises_req && !led) done = 1'b1;
      prev = led;
    end
    check(name, done, rises, rises_req);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      quota[i] = 0; issue_idx[i] = 0; reissue[i] = 0; pend[i] = 1'b0;
      for (int j = 0; j < 4; j++) bl_seq[i][j] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests out of reset, then two continuous requesters.
    quota = '{1, 0, 1, 0}; bl_seq[0][0] = 1; bl_seq[2][0] = 2;
    start_batch(); wait_idle("done_rr_pair");
    quota = '{2, 2, 0, 0};
    bl_seq[0][0] = 1; bl_seq[0][1] = 2; bl_seq[1][0] = 3; bl_seq[1][1] = 1;
    start_batch(); wait_idle("done_alternate");

    quota = '{1, 0, 0, 0}; bl_seq[0][0] = 3;
    start_batch(); wait_idle("done_three_blinks");

    quota = '{0, 0, 0, 1}; bl_seq[3][0] = 0;
    start_batch(); wait_idle("done_zero_blinks");

    quota = '{0, 0, 1, 0}; bl_seq[2][0] = 15;
    start_batch(); wait_idle("done_max_blinks");

    // Reset during the second ON of a 3-blink code; pointer must restart at 0.
    quota = '{0, 0, 1, 0}; bl_seq[2][0] = 3;
    start_batch();
    wait_led_edges("rst_wait", 2, 1'b0);
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NR; i++) begin reissue[i] = 0; pend[i] = 1'b0; end
    model_ptr = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    quota = '{0, 1, 0, 1}; bl_seq[1][0] = 1; bl_seq[3][0] = 2;
    start_batch(); wait_idle("done_after_rst");

    // Requester drops during the OFF of its first blink.
`ifdef LED_SCHED_ABORT_EN
    next_abort_k = HP;
`else
    next_abort_k = -1;
`endif
    quota = '{0, 1, 0, 0}; bl_seq[1][0] = 4;
    start_batch();
    wait_led_edges("drop_wait", 1, 1'b1);
    req[1] = 1'b0;
    wait_idle("done_drop");

    for (int b = 0; b < 8; b++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        quota[i] = $urandom_range(0, 2);
        if (quota[i] > 0) any = 1'b1;
        for (int j = 0; j < 4; j++) bl_seq[i][j] = $urandom_range(0, 6);
      end
      if (!any) quota[$urandom_range(0, NR-1)] = 1;
      start_batch(); wait_idle("done_random");
    end

    check("idle_quiet", idle_err == 0, idle_err, 0);
    check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
